// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer.
// Optional feature macro: COUNTDOWN_AUTOREPEAT_EN (used by countdown_timer).
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_e;

    localparam int unsigned TENS_W      = 3;
    localparam int unsigned ONES_W      = 4;
    localparam int unsigned TENS_MAX    = 5;
    localparam int unsigned ONES_MAX    = 9;
    localparam int unsigned ALARM_CNT_W = 6;

    // Four BCD digits of a mm:ss value, most significant first.
    typedef struct packed {
        logic [TENS_W-1:0] mt;
        logic [ONES_W-1:0] mo;
        logic [TENS_W-1:0] st;
        logic [ONES_W-1:0] so;
    } preset_t;

    // Limit each digit to its legal BCD range.
    function automatic preset_t clamp_preset(input preset_t p);
        preset_t r;
        r.mt = (p.mt > TENS_W'(TENS_MAX)) ? TENS_W'(TENS_MAX) : p.mt;
        r.mo = (p.mo > ONES_W'(ONES_MAX)) ? ONES_W'(ONES_MAX) : p.mo;
        r.st = (p.st > TENS_W'(TENS_MAX)) ? TENS_W'(TENS_MAX) : p.st;
        r.so = (p.so > ONES_W'(ONES_MAX)) ? ONES_W'(ONES_MAX) : p.so;
        return r;
    endfunction

    function automatic logic preset_is_zero(input preset_t p);
        return (p == '0);
    endfunction

    function automatic logic preset_is_one(input preset_t p);
        return (p.mt == '0) && (p.mo == '0) && (p.st == '0) && (p.so == ONES_W'(1));
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit: loadable, wraps 0 -> MAX and raises borrow_o
// when a borrow arrives while the digit already reads zero.
module bcd_down_digit #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic         borrow_i,
    output logic [W-1:0] val_o,
    output logic         borrow_o
);

    logic [W-1:0] val_q, val_d;

    // Next digit value: load has priority, otherwise decrement on borrow.
    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = load_val_i;
        end else if (en_i && borrow_i) begin
            val_d = (val_q == '0) ? W'(MAX) : (val_q - W'(1));
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o    = val_q;
    assign borrow_o = borrow_i && (val_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer with pause, alarm timeout and acknowledge.
// Optional feature macro: COUNTDOWN_AUTOREPEAT_EN -- ALARM exit reloads the
// last accepted preset and resumes counting.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned ALARM_TICKS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              load,
    input  logic [TENS_W-1:0] ld_mt,
    input  logic [ONES_W-1:0] ld_mo,
    input  logic [TENS_W-1:0] ld_st,
    input  logic [ONES_W-1:0] ld_so,
    input  logic              start,
    input  logic              stop,
    input  logic              ack,
    output logic [TENS_W-1:0] mt,
    output logic [ONES_W-1:0] mo,
    output logic [TENS_W-1:0] st,
    output logic [ONES_W-1:0] so,
    output logic              running,
    output logic              done,
    output logic              alarm
);

    state_e                 state_q, state_d;
    logic [ALARM_CNT_W-1:0] acnt_q, acnt_d;
    logic                   done_q, done_d;

    preset_t cur;
    preset_t ld_clamped;
    preset_t dig_val;
    logic    dig_load;
    logic    load_ok;
    logic    dec;
    logic    expire;
    logic    alarm_exit;
    logic    reload;
    logic    cnt_zero;
    logic    b_so, b_st, b_mo;

    assign cur        = {mt, mo, st, so};
    assign ld_clamped = clamp_preset({ld_mt, ld_mo, ld_st, ld_so});
    assign load_ok    = load && ((state_q == ST_IDLE) || (state_q == ST_PAUSE));
    // stop beats a coincident tick: the pause takes effect without a final decrement.
    assign dec        = (state_q == ST_RUN) && tick && !stop && !cnt_zero;
    assign expire     = dec && preset_is_one(cur);
    assign alarm_exit = (state_q == ST_ALARM) &&
                        (ack || (tick && (acnt_q == ALARM_CNT_W'(ALARM_TICKS - 1))));

`ifdef COUNTDOWN_AUTOREPEAT_EN
    preset_t preset_q, preset_d;

    // Shadow copy of the last accepted preset.
    always_comb begin
        preset_d = load_ok ? ld_clamped : preset_q;
    end

    // Preset shadow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            preset_q <= '0;
        end else begin
            preset_q <= preset_d;
        end
    end

    // A zero preset cannot run, so such an exit falls back to IDLE.
    assign reload   = alarm_exit && !preset_is_zero(preset_q);
    assign dig_load = load_ok || reload;
    assign dig_val  = load_ok ? ld_clamped : preset_q;
`else
    assign reload   = 1'b0;
    assign dig_load = load_ok;
    assign dig_val  = ld_clamped;
`endif

    // Digit chain: seconds-ones borrows into seconds-tens and so on; the final
    // borrow out of minutes-tens doubles as the all-zero indication.
    bcd_down_digit #(.W(ONES_W), .MAX(ONES_MAX)) u_so (
        .clk(clk), .rst(rst), .load_i(dig_load), .load_val_i(dig_val.so),
        .en_i(dec), .borrow_i(1'b1), .val_o(so), .borrow_o(b_so)
    );
    bcd_down_digit #(.W(TENS_W), .MAX(TENS_MAX)) u_st (
        .clk(clk), .rst(rst), .load_i(dig_load), .load_val_i(dig_val.st),
        .en_i(dec), .borrow_i(b_so), .val_o(st), .borrow_o(b_st)
    );
    bcd_down_digit #(.W(ONES_W), .MAX(ONES_MAX)) u_mo (
        .clk(clk), .rst(rst), .load_i(dig_load), .load_val_i(dig_val.mo),
        .en_i(dec), .borrow_i(b_st), .val_o(mo), .borrow_o(b_mo)
    );
    bcd_down_digit #(.W(TENS_W), .MAX(TENS_MAX)) u_mt (
        .clk(clk), .rst(rst), .load_i(dig_load), .load_val_i(dig_val.mt),
        .en_i(dec), .borrow_i(b_mo), .val_o(mt), .borrow_o(cnt_zero)
    );

    // Next-state logic; load beats start, stop beats start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!load && start && !stop && !cnt_zero) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_PAUSE;
                end else if (expire) begin
                    state_d = ST_ALARM;
                end
            end
            ST_PAUSE: begin
                if (load) begin
                    state_d = ST_IDLE;
                end else if (start && !stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (alarm_exit) begin
                    state_d = reload ? ST_RUN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Alarm tick counter and expiry pulse: counts ticks only while in ALARM.
    always_comb begin
        acnt_d = '0;
        if ((state_q == ST_ALARM) && !alarm_exit) begin
            acnt_d = tick ? (acnt_q + ALARM_CNT_W'(1)) : acnt_q;
        end
        done_d = expire;
    end

    // State register, alarm counter and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acnt_q  <= acnt_d;
            done_q  <= done_d;
        end
    end

    // Status outputs decoded from registered state.
    always_comb begin
        running = (state_q == ST_RUN);
        alarm   = (state_q == ST_ALARM);
        done    = done_q;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a queue-based scoreboard.
// Optional feature macro: COUNTDOWN_AUTOREPEAT_EN selects the matching expectations.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst, tick, load, start, stop, ack;
    logic [2:0] ld_mt, ld_st;
    logic [3:0] ld_mo, ld_so;
    logic [2:0] mt, st;
    logic [3:0] mo, so;
    logic       running, done, alarm;

    int checks = 0;
    int errors = 0;

    logic [16:0] expq[$];
    string       tagq[$];

    countdown_timer #(.ALARM_TICKS(10)) dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .ld_mt(ld_mt), .ld_mo(ld_mo), .ld_st(ld_st), .ld_so(ld_so),
        .start(start), .stop(stop), .ack(ack),
        .mt(mt), .mo(mo), .st(st), .so(so),
        .running(running), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Expected output vector from a seconds count plus status bits.
    function automatic logic [16:0] ev(input int s, input logic r, input logic d, input logic a);
        logic [2:0] e_mt, e_st;
        logic [3:0] e_mo, e_so;
        e_mt = 3'(s / 600);
        e_mo = 4'((s / 60) % 10);
        e_st = 3'((s % 60) / 10);
        e_so = 4'(s % 10);
        return {e_mt, e_mo, e_st, e_so, r, d, a};
    endfunction

    // Push the expectation, clock once, pop and compare, then drop pulses.
    task automatic step(input string tag, input logic [16:0] exp);
        logic [16:0] obs;
        logic [16:0] want;
        string       t;
        tagq.push_back(tag);
        expq.push_back(exp);
        @(posedge clk);
        #1;
        obs  = {mt, mo, st, so, running, done, alarm};
        want = expq.pop_front();
        t    = tagq.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, want);
        end
        tick  = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic set_preset(input logic [2:0] a, input logic [3:0] b,
                              input logic [2:0] c, input logic [3:0] d);
        ld_mt = a; ld_mo = b; ld_st = c; ld_so = d;
        load  = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step("reset", ev(0, 0, 0, 0));
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
        ld_mt = '0; ld_mo = '0; ld_st = '0; ld_so = '0;
        do_reset();

        // 01:05 full run to expiry
        set_preset(3'd0, 4'd1, 3'd0, 4'd5);
        step("load_0105", ev(65, 0, 0, 0));
        start = 1'b1;
        step("start_0105", ev(65, 1, 0, 0));
        for (int i = 1; i <= 65; i++) begin
            tick = 1'b1;
            if (i == 65) step("expire", ev(0, 0, 1, 1));
            else         step("countdown", ev(65 - i, 1, 0, 0));
        end
        step("done_drop", ev(0, 0, 0, 1));

        // alarm timeout after 10 ticks, start ignored in ALARM
        for (int i = 1; i <= 10; i++) begin
            tick = 1'b1;
            if (i == 3) start = 1'b1;
`ifdef COUNTDOWN_AUTOREPEAT_EN
            if (i == 10) step("alarm_timeout", ev(65, 1, 0, 0));
`else
            if (i == 10) step("alarm_timeout", ev(0, 0, 0, 0));
`endif
            else         step("alarm_hold", ev(0, 0, 0, 1));
        end
        do_reset();

        // zero count start stays idle
        start = 1'b1;
        step("start_zero", ev(0, 0, 0, 0));

        // ack after 3 alarm ticks
        set_preset(3'd0, 4'd0, 3'd0, 4'd1);
        step("load_0001", ev(1, 0, 0, 0));
        start = 1'b1;
        step("start_0001", ev(1, 1, 0, 0));
        tick = 1'b1;
        step("expire_0001", ev(0, 0, 1, 1));
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step("alarm_ticks3", ev(0, 0, 0, 1));
        end
        ack = 1'b1;
`ifdef COUNTDOWN_AUTOREPEAT_EN
        step("ack_exit", ev(1, 1, 0, 0));
`else
        step("ack_exit", ev(0, 0, 0, 0));
`endif
        do_reset();

        // ack coincident with final timeout tick: one exit, no second done
        set_preset(3'd0, 4'd0, 3'd0, 4'd1);
        step("load_0001b", ev(1, 0, 0, 0));
        start = 1'b1;
        step("start_0001b", ev(1, 1, 0, 0));
        tick = 1'b1;
        step("expire_0001b", ev(0, 0, 1, 1));
        for (int i = 0; i < 9; i++) begin
            tick = 1'b1;
            step("alarm_ticks9", ev(0, 0, 0, 1));
        end
        tick = 1'b1; ack = 1'b1;
`ifdef COUNTDOWN_AUTOREPEAT_EN
        step("ack_tick_exit", ev(1, 1, 0, 0));
        step("after_exit", ev(1, 1, 0, 0));
`else
        step("ack_tick_exit", ev(0, 0, 0, 0));
        step("after_exit", ev(0, 0, 0, 0));
`endif
        do_reset();

        // 10:00 borrow chain, pause behaviour
        set_preset(3'd1, 4'd0, 3'd0, 4'd0);
        step("load_1000", ev(600, 0, 0, 0));
        start = 1'b1;
        step("start_1000", ev(600, 1, 0, 0));
        tick = 1'b1;
        step("borrow_chain", ev(599, 1, 0, 0));
        stop = 1'b1;
        step("stop", ev(599, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1;
            step("pause_tick", ev(599, 0, 0, 0));
        end
        start = 1'b1; stop = 1'b1;
        step("start_stop_pause", ev(599, 0, 0, 0));
        start = 1'b1; tick = 1'b1;
        step("resume_with_tick", ev(599, 1, 0, 0));
        tick = 1'b1;
        step("resume_dec", ev(598, 1, 0, 0));
        set_preset(3'd0, 4'd0, 3'd0, 4'd5);
        step("load_in_run", ev(598, 1, 0, 0));
        stop = 1'b1;
        step("stop2", ev(598, 0, 0, 0));
        set_preset(3'd0, 4'd0, 3'd0, 4'd3);
        step("load_in_pause", ev(3, 0, 0, 0));

        // clamp, load beats start
        set_preset(3'd7, 4'd3, 3'd6, 4'd12);
        start = 1'b1;
        step("clamp_load_start", ev(5 * 600 + 3 * 60 + 5 * 10 + 9, 0, 0, 0));
        do_reset();

        // reset mid-run at 00:30
        set_preset(3'd0, 4'd0, 3'd3, 4'd2);
        step("load_0032", ev(32, 0, 0, 0));
        start = 1'b1;
        step("start_0032", ev(32, 1, 0, 0));
        tick = 1'b1;
        step("dec_0031", ev(31, 1, 0, 0));
        tick = 1'b1;
        step("dec_0030", ev(30, 1, 0, 0));
        rst = 1'b1; tick = 1'b1;
        step("rst_mid_run", ev(0, 0, 0, 0));
        rst = 1'b0;
        step("no_done_after_rst", ev(0, 0, 0, 0));
        start = 1'b1;
        step("start_after_rst", ev(0, 0, 0, 0));

`ifdef COUNTDOWN_AUTOREPEAT_EN
        // autorepeat reload on ack
        set_preset(3'd0, 4'd0, 3'd0, 4'd2);
        step("ar_load", ev(2, 0, 0, 0));
        start = 1'b1;
        step("ar_start", ev(2, 1, 0, 0));
        tick = 1'b1;
        step("ar_tick1", ev(1, 1, 0, 0));
        tick = 1'b1;
        step("ar_expire", ev(0, 0, 1, 1));
        ack = 1'b1;
        step("ar_ack_reload", ev(2, 1, 0, 0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
